// File: rtl/spi_msg_pkg.sv
// rtl/spi_msg_pkg.sv - shared opcode, command byte and state definitions for SPI message layer
//
// Purpose: constants and helpers common to the master and the slave-side
//          message interface.
//   - Request opcodes: STATUS, RDREG, WRREG, reserved.
//   - Command bytes: CMD_STATUS, CMD_RDREG/CMD_WRREG nibble prefixes, DUMMY.
//   - Message FSM state encoding.
//   - msgByte():     byte n of a message.
//   - lastByteIdx(): index of the final byte of a message.
package spi_msg_pkg;

    localparam logic [1:0] OP_STATUS = 2'd0;
    localparam logic [1:0] OP_RDREG  = 2'd1;
    localparam logic [1:0] OP_WRREG  = 2'd2;
    localparam logic [1:0] OP_RSVD   = 2'd3;

    localparam logic [7:0] CMD_STATUS = 8'h00;
    localparam logic [3:0] CMD_RDREG  = 4'b1000;
    localparam logic [3:0] CMD_WRREG  = 4'b1100;
    localparam logic [7:0] DUMMY      = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_GAP  = 2'd3
    } msgState_t;

    // STATUS is two bytes long; the register messages are five bytes long.
    function automatic logic [2:0] lastByteIdx(input logic [1:0] op);
        return (op == OP_STATUS) ? 3'd1 : 3'd4;
    endfunction

    function automatic logic [7:0] msgByte(input logic [1:0]  op,
                                           input logic [3:0]  regIdx,
                                           input logic [31:0] data,
                                           input logic [2:0]  idx);
        logic [7:0] b;
        b = DUMMY;
        case (op)
            OP_STATUS: b = (idx == 3'd0) ? CMD_STATUS : DUMMY;
            OP_RDREG:  b = (idx == 3'd0) ? {CMD_RDREG, regIdx} : DUMMY;
            OP_WRREG: begin
                case (idx)
                    3'd0:    b = {CMD_WRREG, regIdx};
                    3'd1:    b = data[31:24];
                    3'd2:    b = data[23:16];
                    3'd3:    b = data[15:8];
                    3'd4:    b = data[7:0];
                    default: b = DUMMY;
                endcase
            end
            default: b = DUMMY;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/spi_msg_master.sv
// rtl/spi_msg_master.sv - message-level SPI master driving a byte exchange layer
//
// Purpose: turns a STATUS / RDREG / WRREG request into a sequence of byte
//          exchanges and collects the response bytes.
// Ports:
//   sysClk, usrReset         clock, asynchronous active-high reset
//   req, reqOp, reqReg,      request handshake: sampled only when busy=0
//   reqData
//   busy, done, err          message in progress / end pulse / timeout abort flag
//   rdData, status           last RDREG value / last STATUS byte (held)
//   msgActive                slave-select frame for the byte layer
//   txStart, tx              start strobe and byte to shift out
//   rxValid, rx              byte exchange complete strobe and received byte
import spi_msg_pkg::*;

module spi_msg_master #(
    parameter int byteGap = 2,
    parameter int timeout = 1024
) (
    input  logic        sysClk,
    input  logic        usrReset,
    input  logic        req,
    input  logic [1:0]  reqOp,
    input  logic [3:0]  reqReg,
    input  logic [31:0] reqData,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdData,
    output logic [7:0]  status,
    output logic        msgActive,
    output logic        txStart,
    output logic [7:0]  tx,
    input  logic        rxValid,
    input  logic [7:0]  rx
);

    localparam int TMO_W = $clog2(timeout);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(timeout - 1);
    localparam logic [7:0] GAP_LAST = (byteGap > 0) ? 8'(byteGap - 1) : 8'd0;

    msgState_t state;
    msgState_t nextState;

    logic [1:0]       curOp;
    logic [3:0]       curReg;
    logic [31:0]      curData;
    logic [2:0]       byteIdx;
    logic [7:0]       gapCnt;
    logic [TMO_W-1:0] tmoCnt;
    logic [23:0]      rdShadow;

    logic       accept;
    logic       loadTx;
    logic       byteDone;
    logic       finish;
    logic       abort;
    logic       lastByte;
    logic [1:0] selOp;
    logic [3:0] selReg;
    logic [31:0] selData;
    logic [2:0] selIdx;
    logic [7:0] nextTx;

    assign accept   = (state == ST_IDLE) && req && (reqOp != OP_RSVD);
    assign lastByte = (byteIdx == lastByteIdx(curOp));

    // The first byte is built straight from the request inputs on the accept
    // edge; later bytes come from the latched request. Going WAIT->SEND directly
    // (no gap) happens on the same edge that advances byteIdx, hence the +1.
    always_comb begin
        selOp   = curOp;
        selReg  = curReg;
        selData = curData;
        selIdx  = byteIdx;
        if (state == ST_IDLE) begin
            selOp   = reqOp;
            selReg  = reqReg;
            selData = reqData;
            selIdx  = 3'd0;
        end else if (state == ST_WAIT) begin
            selIdx  = byteIdx + 3'd1;
        end
        nextTx = msgByte(selOp, selReg, selData, selIdx);
    end

    always_ff @(posedge sysClk or posedge usrReset) begin
        if (usrReset) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        loadTx    = 1'b0;
        byteDone  = 1'b0;
        finish    = 1'b0;
        abort     = 1'b0;
        busy      = 1'b0;
        msgActive = 1'b0;
        txStart   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    nextState = ST_SEND;
                    loadTx    = 1'b1;
                end
            end
            ST_SEND: begin
                busy      = 1'b1;
                msgActive = 1'b1;
                txStart   = 1'b1;
                nextState = ST_WAIT;
            end
            ST_WAIT: begin
                busy      = 1'b1;
                msgActive = 1'b1;
                // rxValid is checked first so it beats a simultaneous timeout.
                if (rxValid) begin
                    byteDone = 1'b1;
                    if (lastByte) begin
                        nextState = ST_IDLE;
                        finish    = 1'b1;
                    end else if (byteGap == 0) begin
                        nextState = ST_SEND;
                        loadTx    = 1'b1;
                    end else begin
                        nextState = ST_GAP;
                    end
                end else if (tmoCnt == TMO_LAST) begin
                    nextState = ST_IDLE;
                    abort     = 1'b1;
                end
            end
            ST_GAP: begin
                busy      = 1'b1;
                msgActive = 1'b1;
                if (gapCnt == GAP_LAST) begin
                    nextState = ST_SEND;
                    loadTx    = 1'b1;
                end
            end
            default: nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge sysClk or posedge usrReset) begin
        if (usrReset) begin
            curOp    <= OP_STATUS;
            curReg   <= 4'd0;
            curData  <= 32'd0;
            byteIdx  <= 3'd0;
            gapCnt   <= 8'd0;
            tmoCnt   <= '0;
            rdShadow <= 24'd0;
            tx       <= 8'h00;
            done     <= 1'b0;
            err      <= 1'b0;
            rdData   <= 32'd0;
            status   <= 8'h00;
        end else begin
            done <= finish | abort;
            err  <= abort;

            if (accept) begin
                curOp   <= reqOp;
                curReg  <= reqReg;
                curData <= reqData;
                byteIdx <= 3'd0;
            end else if (byteDone) begin
                byteIdx <= byteIdx + 3'd1;
            end

            if (loadTx) begin
                tx <= nextTx;
            end

            // The SEND cycle counts as the first cycle of the timeout window.
            if (state == ST_SEND) begin
                tmoCnt <= TMO_W'(1);
            end else if (state == ST_WAIT) begin
                tmoCnt <= tmoCnt + TMO_W'(1);
            end

            if (state == ST_GAP) begin
                gapCnt <= gapCnt + 8'd1;
            end else begin
                gapCnt <= 8'd0;
            end

            // Byte 0 echoes nothing useful; RDREG data bytes are staged so an
            // aborted read leaves rdData untouched.
            if (byteDone && (byteIdx != 3'd0)) begin
                rdShadow <= {rdShadow[15:0], rx};
            end

            if (finish) begin
                if (curOp == OP_RDREG) begin
                    rdData <= {rdShadow, rx};
                end
                if (curOp == OP_STATUS) begin
                    status <= rx;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_msg_master.sv
// tb/tb_spi_msg_master.sv - scoreboard testbench for spi_msg_master
module tb_spi_msg_master;

    localparam int GAP = 2;
    localparam int TMO = 16;

    logic        sysClk = 1'b0;
    logic        usrReset = 1'b1;
    logic        req = 1'b0;
    logic [1:0]  reqOp = 2'd0;
    logic [3:0]  reqReg = 4'd0;
    logic [31:0] reqData = 32'd0;
    logic        busy, done, err, msgActive, txStart;
    logic [31:0] rdData;
    logic [7:0]  status, tx;
    logic        rxValid = 1'b0;
    logic [7:0]  rx = 8'h00;

    spi_msg_master #(.byteGap(GAP), .timeout(TMO)) dut (
        .sysClk(sysClk), .usrReset(usrReset), .req(req), .reqOp(reqOp),
        .reqReg(reqReg), .reqData(reqData), .busy(busy), .done(done), .err(err),
        .rdData(rdData), .status(status), .msgActive(msgActive), .txStart(txStart),
        .tx(tx), .rxValid(rxValid), .rx(rx)
    );

    always #5 sysClk = ~sysClk;

    typedef struct {
        logic        err;
        logic [31:0] rd;
        logic [7:0]  st;
        bit          chkTmo;
    } doneExp_t;

    typedef struct {
        int         dly;
        logic [7:0] data;
    } rsp_t;

    logic [7:0] txQ[$];
    doneExp_t   doneQ[$];
    rsp_t       modelQ[$];

    int nCmp = 0;
    int nMis = 0;
    int cyc = 0;
    int acceptCyc = 0;
    int lastRxCyc = 0;
    int lastTxCyc = 0;
    int msgTx = 0;

    always @(posedge sysClk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Byte-layer model: answers each txStart after the queued delay; dly<0 means silent.
    initial begin
        rsp_t ent;
        forever begin
            @(negedge sysClk);
            if (txStart && !usrReset) begin
                if (modelQ.size() == 0) begin
                    ent.dly = -1;
                    ent.data = 8'h00;
                end else begin
                    ent = modelQ.pop_front();
                end
                if (ent.dly >= 1) begin
                    repeat (ent.dly) @(posedge sysClk);
                    #1;
                    rxValid = 1'b1;
                    rx = ent.data;
                    @(posedge sysClk);
                    #1;
                    rxValid = 1'b0;
                end
            end
        end
    end

    // Monitor: compares every txStart and done against the scoreboard queues.
    initial begin
        logic [7:0] expTx;
        doneExp_t   de;
        forever begin
            @(negedge sysClk);
            if (usrReset) begin
                msgTx = 0;
            end else begin
                if (rxValid && busy) lastRxCyc = cyc;
                if (txStart) begin
                    if (txQ.size() == 0) begin
                        chk("tx_unexpected", {24'd0, tx}, 32'hFFFF_FFFF);
                    end else begin
                        expTx = txQ.pop_front();
                        chk("tx_byte", {24'd0, tx}, {24'd0, expTx});
                    end
                    if (msgTx == 0) chk("first_tx_latency", cyc - acceptCyc, 1);
                    else            chk("byte_gap", cyc - lastRxCyc, GAP + 1);
                    msgTx++;
                    lastTxCyc = cyc;
                end
                if (done) begin
                    if (doneQ.size() == 0) begin
                        chk("done_unexpected", {31'd0, done}, 32'd0);
                    end else begin
                        de = doneQ.pop_front();
                        chk("done_err", {31'd0, err}, {31'd0, de.err});
                        chk("done_rdData", rdData, de.rd);
                        chk("done_status", {24'd0, status}, {24'd0, de.st});
                        chk("done_busy", {31'd0, busy}, 32'd0);
                        if (de.chkTmo) chk("timeout_latency", cyc - lastTxCyc, TMO);
                    end
                    msgTx = 0;
                end else if (err) begin
                    chk("err_without_done", {31'd0, err}, 32'd0);
                end
            end
        end
    end

    task automatic pushRsp(input int d, input logic [7:0] b);
        rsp_t r;
        r.dly = d;
        r.data = b;
        modelQ.push_back(r);
    endtask

    task automatic pushDone(input logic e, input logic [31:0] rd, input logic [7:0] st, input bit t);
        doneExp_t d;
        d.err = e;
        d.rd = rd;
        d.st = st;
        d.chkTmo = t;
        doneQ.push_back(d);
    endtask

    task automatic sendReq(input logic [1:0] op, input logic [3:0] r, input logic [31:0] d);
        reqOp = op;
        reqReg = r;
        reqData = d;
        req = 1'b1;
        acceptCyc = cyc;
        @(posedge sysClk);
        #1;
        req = 1'b0;
    endtask

    task automatic waitIdle(input int maxCyc);
        int n;
        n = 0;
        do begin
            @(posedge sysClk);
            #1;
            n++;
        end while (busy && n < maxCyc);
        if (busy) chk("wait_idle_bound", {31'd0, busy}, 32'd0);
    endtask

    task automatic chkResetOutputs();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_msgActive", {31'd0, msgActive}, 32'd0);
        chk("rst_txStart", {31'd0, txStart}, 32'd0);
        chk("rst_tx", {24'd0, tx}, 32'd0);
        chk("rst_rdData", rdData, 32'd0);
        chk("rst_status", {24'd0, status}, 32'd0);
    endtask

    initial begin
        int n;
        logic [31:0] expRd;
        logic [7:0]  expSt;
        expRd = 32'd0;
        expSt = 8'h00;

        repeat (2) @(posedge sysClk);
        #1;
        chkResetOutputs();
        usrReset = 1'b0;
        @(posedge sysClk);
        #1;

        // WRREG reg 3 <= 0x12345678
        txQ.push_back(8'hC3); txQ.push_back(8'h12); txQ.push_back(8'h34);
        txQ.push_back(8'h56); txQ.push_back(8'h78);
        for (int i = 0; i < 5; i++) pushRsp(8, 8'h00);
        pushDone(1'b0, expRd, expSt, 1'b0);
        sendReq(2'd2, 4'd3, 32'h1234_5678);
        chk("msgActive_in_msg", {31'd0, msgActive}, 32'd1);
        waitIdle(300);

        // RDREG reg 5 -> 0xDEADBEEF
        txQ.push_back(8'h85);
        for (int i = 0; i < 4; i++) txQ.push_back(8'h00);
        pushRsp(8, 8'h11); pushRsp(8, 8'hDE); pushRsp(8, 8'hAD);
        pushRsp(8, 8'hBE); pushRsp(8, 8'hEF);
        expRd = 32'hDEAD_BEEF;
        pushDone(1'b0, expRd, expSt, 1'b0);
        sendReq(2'd1, 4'd5, 32'hFFFF_FFFF);
        waitIdle(300);

        // STATUS issued in the done cycle of the previous message
        txQ.push_back(8'h00); txQ.push_back(8'h00);
        pushRsp(8, 8'h77); pushRsp(8, 8'h5A);
        expSt = 8'h5A;
        pushDone(1'b0, expRd, expSt, 1'b0);
        sendReq(2'd0, 4'd0, 32'd0);
        waitIdle(300);

        // RDREG reg 9, slave silent on byte 3 -> timeout abort
        txQ.push_back(8'h89); txQ.push_back(8'h00); txQ.push_back(8'h00);
        pushRsp(8, 8'h01); pushRsp(8, 8'h02); pushRsp(-1, 8'h00);
        pushDone(1'b1, expRd, expSt, 1'b1);
        sendReq(2'd1, 4'd9, 32'd0);
        waitIdle(300);
        @(posedge sysClk);
        #1;
        chk("err_after_abort", {31'd0, err}, 32'd0);

        // Reserved opcode and stray rxValid while idle
        sendReq(2'd3, 4'd1, 32'd0);
        chk("rsvd_no_busy", {31'd0, busy}, 32'd0);
        rxValid = 1'b1;
        rx = 8'hFF;
        @(posedge sysClk);
        #1;
        rxValid = 1'b0;
        repeat (3) @(posedge sysClk);
        #1;
        chk("idle_rx_busy", {31'd0, busy}, 32'd0);
        chk("idle_rx_status", {24'd0, status}, {24'd0, expSt});
        chk("idle_rx_rdData", rdData, expRd);

        // STATUS with a WRREG request pulsed while busy
        txQ.push_back(8'h00); txQ.push_back(8'h00);
        pushRsp(8, 8'h00); pushRsp(8, 8'h3C);
        expSt = 8'h3C;
        pushDone(1'b0, expRd, expSt, 1'b0);
        sendReq(2'd0, 4'd0, 32'd0);
        repeat (3) @(posedge sysClk);
        #1;
        reqOp = 2'd2; reqReg = 4'd7; reqData = 32'hCAFE_F00D; req = 1'b1;
        repeat (2) @(posedge sysClk);
        #1;
        req = 1'b0;
        waitIdle(300);
        repeat (4) @(posedge sysClk);
        #1;
        chk("busy_req_not_queued", {31'd0, busy}, 32'd0);

        // rxValid on the exact timeout edge wins
        txQ.push_back(8'h00); txQ.push_back(8'h00);
        pushRsp(8, 8'h00); pushRsp(TMO - 1, 8'h42);
        expSt = 8'h42;
        pushDone(1'b0, expRd, expSt, 1'b0);
        sendReq(2'd0, 4'd0, 32'd0);
        waitIdle(300);

        // Reset during WAIT of byte 3 of an RDREG
        txQ.push_back(8'h82); txQ.push_back(8'h00); txQ.push_back(8'h00);
        pushRsp(8, 8'h00); pushRsp(8, 8'h99); pushRsp(-1, 8'h00);
        sendReq(2'd1, 4'd2, 32'd0);
        n = 0;
        while (msgTx < 3 && n < 200) begin
            @(posedge sysClk);
            #1;
            n++;
        end
        chk("reach_byte3", msgTx, 3);
        repeat (3) @(posedge sysClk);
        #1;
        chk("pre_reset_busy", {31'd0, busy}, 32'd1);
        usrReset = 1'b1;
        #1;
        chkResetOutputs();
        @(posedge sysClk);
        #1;
        chkResetOutputs();
        txQ.delete();
        doneQ.delete();
        modelQ.delete();
        usrReset = 1'b0;
        expRd = 32'd0;
        expSt = 8'h00;
        repeat (2) @(posedge sysClk);
        #1;

        // STATUS after reset release
        txQ.push_back(8'h00); txQ.push_back(8'h00);
        pushRsp(8, 8'h00); pushRsp(8, 8'hA5);
        expSt = 8'hA5;
        pushDone(1'b0, expRd, expSt, 1'b0);
        sendReq(2'd0, 4'd0, 32'd0);
        waitIdle(300);
        repeat (2) @(posedge sysClk);
        #1;

        chk("txQ_drained", txQ.size(), 0);
        chk("doneQ_drained", doneQ.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nMis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

endmodule

// File: doc/spi_msg_master.md
SPI_MSG_MASTER -- requirements
Module: spi_msg_master

Interface
REQ-001 Parameter: byteGap, 2, idle sysClk cycles between consecutive bytes of one message (0..255).
REQ-002 Parameter: timeout, 1024, max sysClk cycles waiting for rxValid after txStart before abort (>=2).
REQ-003 sysClk  in  1  single clock; all logic on rising edge.
REQ-004 usrReset  in  1  asynchronous, active-high reset.
REQ-005 req  in  1  message request; sampled only when busy=0.
REQ-006 reqOp  in  2  0=STATUS, 1=RDREG, 2=WRREG, 3=reserved (ignored, no busy).
REQ-007 reqReg  in  4  register index for RDREG/WRREG.
REQ-008 reqData  in  32  write value for WRREG.
REQ-009 busy  out  1  message in progress.
REQ-010 done  out  1  one-cycle pulse at message end.
REQ-011 err  out  1  valid with done; 1 = timeout abort.
REQ-012 rdData  out  32  register value from last RDREG; held until next RDREG done.
REQ-013 status  out  8  status byte from last STATUS; held until next STATUS done.
REQ-014 msgActive  out  1  frame for byte layer (slave select); high from first txStart to done.
REQ-015 txStart  out  1  one-cycle strobe: byte layer starts one byte exchange.
REQ-016 tx  out  8  byte to shift out; stable from txStart until rxValid.
REQ-017 rxValid  in  1  one-cycle strobe: byte exchange complete, rx valid.
REQ-018 rx  in  8  byte shifted in during the completed exchange.

Function
REQ-019 Request accepted on edge where req=1, busy=0, reqOp!=3; reqOp/reqReg/reqData latched that edge.
REQ-020 States: IDLE, SEND, WAIT, GAP; IDLE->SEND on accept; SEND->WAIT after one cycle; WAIT->GAP on rxValid if bytes remain; WAIT->IDLE on rxValid of last byte or timeout; GAP->SEND after byteGap cycles (byteGap=0: GAP lasts 0 cycles, WAIT->SEND directly).
REQ-021 busy and msgActive high in SEND/WAIT/GAP; txStart high only in SEND; first txStart is the cycle after acceptance.
REQ-022 Byte sequences: STATUS = 0x00, 0x00 (2 bytes); RDREG = {4'b1000,reqReg}, 0x00 x4 (5 bytes); WRREG = {4'b1100,reqReg}, reqData[31:24], [23:16], [15:8], [7:0] (5 bytes).
REQ-023 STATUS: rx of byte 2 -> status. RDREG: rx of bytes 2..5 -> rdData[31:24],[23:16],[15:8],[7:0]; rdData updated only at done with err=0 (assembled in shadow). rx of byte 1 always discarded.
REQ-024 done pulses the cycle after the last rxValid (or timeout) edge, concurrent with return to IDLE; busy low same cycle; a new req may be accepted that cycle.
REQ-025 Timeout counter restarts at each txStart; reaching timeout cycles in WAIT without rxValid -> done=1, err=1, rdData/status unchanged.
REQ-026 rxValid and timeout expiry on same edge: rxValid wins, no error.
REQ-027 rxValid outside WAIT ignored; req while busy ignored (not queued).
REQ-028 err low except during done pulse of an aborted message.

Reset
REQ-029 On usrReset: state IDLE, busy=0, done=0, err=0, msgActive=0, txStart=0, tx=0x00, rdData=0, status=0, counters 0.
REQ-030 Reset mid-message aborts immediately without done pulse; first req after release accepted normally.

Structure
REQ-031 Shared package spi_msg_pkg: opcode constants, CMD_STATUS=0x00, CMD_RDREG prefix 4'b1000, CMD_WRREG prefix 4'b1100, DUMMY=0x00, state encoding; also used by the slave-side message interface.
REQ-032 Single module, no sub-modules; byte index counter (0..4), gap counter, timeout counter inside.

Verification
REQ-033 WRREG reg 3, 0x12345678, byteGap=2, byte model answers in 8 cycles -> tx C3,12,34,56,78, five txStart, >=2 idle cycles between, done err=0.
REQ-034 RDREG reg 5, model returns xx,DE,AD,BE,EF -> tx 85,00,00,00,00, rdData=0xDEADBEEF at done.
REQ-035 STATUS, model returns xx,5A -> tx 00,00, status=0x5A, rdData unchanged.
REQ-036 RDREG with model silent after byte 3, timeout=16 -> done with err=1 16 cycles after third txStart, rdData unchanged.
REQ-037 req pulsed during busy and rxValid injected in IDLE -> no effect; rxValid on exact timeout edge -> err=0.
REQ-038 usrReset asserted in WAIT of byte 3 -> all outputs reset values, no done; next STATUS completes correctly.
